// File: rtl/reg8file_pkg.sv
// Shared default sizing for the reg8file register file and its cells.
package reg8file_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_NREGS  = 8;
  localparam int unsigned DEF_SEL_W  = $clog2(DEF_NREGS);
endpackage

// File: rtl/reg8file_if.sv
// Write/read port bundle of the register file; the top acts as slave.
interface reg8file_if
  import reg8file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SEL_W  = DEF_SEL_W
);
  logic              en;
  logic [SEL_W-1:0]  wsel;
  logic [DATA_W-1:0] d;
  logic [SEL_W-1:0]  rsel;
  logic [DATA_W-1:0] q;

  modport master (output en, output wsel, output d, output rsel, input q);
  modport slave  (input en, input wsel, input d, input rsel, output q);
endinterface

// File: rtl/reg8_cell.sv
// One DATA_W-bit storage register; synchronous clear beats load.
module reg8_cell
  import reg8file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (clr) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/reg8file.sv
// NREGS x DATA_W register file: one-hot write decode into reg8_cell
// instances and a combinational read mux with no write bypass.
module reg8file
  import reg8file_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input logic       clk,
  input logic       clr,
  reg8file_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NREGS);

  logic [NREGS-1:0]  cell_en;
  logic [DATA_W-1:0] cell_q [NREGS];

  // Write decoder: at most one cell enabled per cycle.
  always_comb begin
    cell_en = '0;
    if (bus.en) cell_en[bus.wsel] = 1'b1;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    reg8_cell #(.DATA_W(DATA_W)) u_cell (
      .clk (clk),
      .clr (clr),
      .en  (cell_en[i]),
      .d   (bus.d),
      .q   (cell_q[i])
    );
  end

  // NREGS is a power of two, so every rsel selects a real cell.
  assign bus.q = cell_q[bus.rsel];
endmodule

// File: tb/tb_reg8file.sv
// Self-checking bench for reg8file: directed vector table plus a
// model-driven random phase, both feeding an expected-value queue.
module tb_reg8file;
  import reg8file_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned NR = DEF_NREGS;
  localparam int unsigned SW = DEF_SEL_W;

  typedef struct {
    string         name;
    logic          tick;
    logic          clr;
    logic          en;
    logic [SW-1:0] wsel;
    logic [DW-1:0] d;
    logic [SW-1:0] rsel;
    logic [DW-1:0] exp_q;
  } vec_t;

  logic clk = 1'b0;
  logic clr;

  reg8file_if bus ();

  reg8file dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_fifo [$];
  logic [DW-1:0] model    [NR];
  vec_t          vecs     [$];

  // Drive at negedge; compare just after the next posedge (tick) or 1ns later.
  task automatic apply(input vec_t v);
    logic [DW-1:0] want;
    @(negedge clk);
    clr      = v.clr;
    bus.en   = v.en;
    bus.wsel = v.wsel;
    bus.d    = v.d;
    bus.rsel = v.rsel;
    exp_fifo.push_back(v.exp_q);
    if (v.tick) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
    want = exp_fifo.pop_front();
    n_total++;
    if (bus.q === want) n_pass++;
    else $display("FAIL %s: rsel=%0d q=%h expected %h", v.name, v.rsel, bus.q, want);
  endtask

  function automatic vec_t mk(input string name, input logic tick, input logic c,
                              input logic e, input int ws, input logic [DW-1:0] dd,
                              input int rs, input logic [DW-1:0] ex);
    vec_t v;
    v.name = name; v.tick = tick; v.clr = c; v.en = e;
    v.wsel = SW'(ws); v.d = dd; v.rsel = SW'(rs); v.exp_q = ex;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] iso [NR];
    vec_t          v;

    clr = 1'b1; bus.en = 1'b0; bus.wsel = '0; bus.d = '0; bus.rsel = '0;

    // Reset, and q stays 0 for every rsel while clr is held.
    vecs.push_back(mk("reset_edge", 1, 1, 0, 0, 8'h00, 0, 8'h00));
    for (int i = 0; i < NR; i++) vecs.push_back(mk("reset_sweep", 0, 1, 0, 0, 8'h00, i, 8'h00));
    // Walking one, checked right after each edge, then swept back.
    for (int i = 0; i < NR; i++) vecs.push_back(mk("walk_write", 1, 0, 1, i, DW'(1 << i), i, DW'(1 << i)));
    for (int i = 0; i < NR; i++) vecs.push_back(mk("walk_sweep", 0, 0, 0, 0, 8'h00, i, DW'(1 << i)));
    // Write disabled with a live address and data.
    for (int i = 0; i < 3; i++) vecs.push_back(mk("write_disabled", 1, 0, 0, 3, 8'hFF, 3, 8'h08));
    // Same-address read/write: old value before the edge, new after.
    vecs.push_back(mk("same_addr_pre", 0, 0, 1, 2, 8'h5A, 2, 8'h04));
    vecs.push_back(mk("same_addr_post", 1, 0, 1, 2, 8'h5A, 2, 8'h5A));
    // Isolation: write register 6 only.
    vecs.push_back(mk("iso_write", 1, 0, 1, 6, 8'hC3, 6, 8'hC3));
    iso = '{8'h01, 8'h02, 8'h5A, 8'h08, 8'h10, 8'h20, 8'hC3, 8'h80};
    for (int i = 0; i < NR; i++) vecs.push_back(mk("iso_sweep", 0, 0, 0, 0, 8'h00, i, iso[i]));
    // Clear beats a simultaneous write.
    vecs.push_back(mk("clr_priority", 1, 1, 1, 5, 8'hAA, 5, 8'h00));
    for (int i = 0; i < NR; i++) vecs.push_back(mk("clr_sweep", 0, 0, 0, 0, 8'h00, i, 8'h00));
    // First edge after clr release accepts a write.
    vecs.push_back(mk("post_clr_write", 1, 0, 1, 7, 8'h3C, 7, 8'h3C));

    foreach (vecs[k]) apply(vecs[k]);

    // Random phase against a behavioural model; starts with a forced clear.
    for (int n = 0; n < 80; n++) begin
      v.name = "random";
      v.tick = 1'b1;
      v.clr  = (n == 0) || ($urandom_range(0, 15) == 0);
      v.en   = 1'($urandom_range(0, 1));
      v.wsel = SW'($urandom_range(0, NR - 1));
      v.d    = DW'($urandom);
      v.rsel = (n % 3 == 0) ? v.wsel : SW'($urandom_range(0, NR - 1));
      if (v.clr) foreach (model[r]) model[r] = '0;
      else if (v.en) model[v.wsel] = v.d;
      v.exp_q = model[v.rsel];
      apply(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
